ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction-fetch stage that produces the PC/instruction pair consumed by the IF/ID pipeline buffer. Holds the program counter and issues word reads to instruction memory over a req/ack handshake. Absorbs variable memory latency, hazard-unit stalls and branch redirects, and presents registered `out_pc`/`out_inst`/`out_valid` that the IF/ID buffer samples on the rising edge.

## Interface
- `WIDTH`, 33: width of all PC, address and instruction buses; matches the IF/ID buffer ports.
- `RESET_PC`, 0: PC value loaded on reset.
- `PC_STEP`, 1: PC increment per fetched word.
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hazard unit hold; `out_*` must not change while high.
- `redirect` in 1: branch/jump taken; flush and refetch from `redirect_pc`.
- `redirect_pc` in WIDTH: new fetch address, valid when `redirect`=1.
- `imem_req` out 1: read request, level.
- `imem_addr` out WIDTH: read address, equals current PC.
- `imem_ack` in 1: read data valid this cycle; completes the request.
- `imem_rdata` in WIDTH: instruction word, valid with `imem_ack`.
- `out_pc` out WIDTH: PC of the presented instruction.
- `out_inst` out WIDTH: presented instruction.
- `out_valid` out 1: `out_pc`/`out_inst` hold a real instruction; 0 means bubble.

## Operation
- States: FETCH, HOLD, DRAIN. Reset → FETCH, `pc`=RESET_PC, `out_pc`=0, `out_inst`=0, `out_valid`=0, skid register=0.
- Handshake: `imem_req`=1 in FETCH and DRAIN, 0 in HOLD and while `rst`=1. `imem_addr` stays stable from assertion until the ack cycle. Transfer happens when `imem_req && imem_ack`.
- FETCH, ack, `stall`=0: load `out_pc`←pc, `out_inst`←imem_rdata, `out_valid`←1, pc←pc+PC_STEP. Stay in FETCH; the next request issues in the following cycle.
- FETCH, ack, `stall`=1: write the pair into the skid register, pc←pc+PC_STEP, go to HOLD. `out_*` unchanged.
- FETCH, no ack, `stall`=0: `out_valid`←0 (bubble). No ack with `stall`=1: `out_*` unchanged.
- HOLD: no request. When `stall`=0, move the skid pair to `out_*` with `out_valid`←1 and return to FETCH.
- Redirect has the highest priority and overrides `stall`. It always sets `out_valid`←0 and `out_inst`←0, and sets pc←`redirect_pc`. Further action depends on state:
  - FETCH with a request pending and no ack this cycle: go to DRAIN.
  - FETCH with ack in the same cycle: discard the data and stay in FETCH.
  - HOLD: discard the skid pair and go to FETCH.
  - DRAIN: update the target and stay in DRAIN.
- DRAIN: keep `imem_addr` at the old address until ack. Discard the data, then go to FETCH at the redirect PC. `out_valid` stays 0.
- PC arithmetic: modulo 2^WIDTH; the wrap from all-ones to 0 is silent.
- `rst` asserted mid-transaction: the outstanding request is abandoned. Memory must tolerate `imem_req` dropping before ack.

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle. `out_*` update on the edge ending the ack cycle.
- N-cycle memory latency: N bubble cycles (`out_valid`=0) per instruction.
- Redirect to first valid output at the new PC:
  - 1 cycle plus memory latency from FETCH/HOLD.
  - Additionally the remaining old-request latency from DRAIN.
- Stall release from HOLD: valid output on the next edge, with no memory access.
- All outputs are registered except `imem_req`/`imem_addr`, which decode from state and pc.

## Configuration
- `IFETCH_PERFCNT_EN` defined: adds outputs `perf_fetched` (32, out) and `perf_bubbles` (32, out).
  - `perf_fetched` counts cycles with `out_valid` loaded to 1.
  - `perf_bubbles` counts cycles with `out_valid` loaded to 0.
  - Both counters clear on `rst` and saturate at 0xFFFFFFFF.
- Not defined: neither port nor the counters exist; behaviour is otherwise identical.

## Test plan
- Reset release, zero-wait memory returning addr+0x100: `out_pc` 0,1,2,3 on consecutive cycles, `out_inst` 0x100..0x103, `out_valid`=1 from the second edge.
- Ack every 3rd cycle: `out_valid` pattern 0,0,1 repeating, and pc advances only on ack.
- `stall`=1 for 4 cycles coinciding with an ack for pc=5:
  - `out_*` frozen and `imem_req`=0 after the ack.
  - pc=5 appears one edge after `stall` drops, with no second read of address 5.
- Redirect to 0x40 while the request for pc=7 is pending 2 more cycles:
  - `imem_addr` stays 7 until ack; the data is discarded.
  - Next request to 0x40; no `out_valid` for pc 7.
- Redirect and `stall` asserted together in HOLD: skid discarded, `out_valid`=0, next fetch at `redirect_pc`.
- pc at 2^33−1, ack: next `imem_addr`=0. `rst` mid-wait: `imem_req`=0 and all outputs 0 in the next cycle.

Source files
------------

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage feeding the IF/ID buffer.
// Holds the PC and issues word reads over a level req/ack handshake.
// It absorbs memory latency, hazard stalls (using a one-entry skid register)
// and branch redirects. A redirect that arrives while a read is still
// outstanding first drains that read.
// Optional feature: define IFETCH_PERFCNT_EN to add the perf_fetched and
// perf_bubbles saturating counters.
module ifetch_unit #(
   parameter int              WIDTH    = 33,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_ack,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic [WIDTH-1:0] out_pc,
   output logic [WIDTH-1:0] out_inst,
`ifdef IFETCH_PERFCNT_EN
   output logic [31:0]      perf_fetched,
   output logic [31:0]      perf_bubbles,
`endif
   output logic             out_valid
);

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] pc, pc_n;
   logic [WIDTH-1:0] tgt, tgt_n;
   logic [WIDTH-1:0] skid_pc, skid_pc_n;
   logic [WIDTH-1:0] skid_inst, skid_inst_n;
   logic [WIDTH-1:0] opc_n, oinst_n;
   logic             ovalid_n, ovalid_we;
   logic             xfer;

   // Request decodes from state only, so imem_addr stays on the old pc in
   // DRAIN. The redirect target is parked in tgt until the old read acks.
   assign imem_req  = !rst && (state != HOLD);
   assign imem_addr = pc;
   assign xfer      = imem_req && imem_ack;

   // Next-state, pc and output-register decode
   always_comb begin
      state_n     = state;
      pc_n        = pc;
      tgt_n       = tgt;
      skid_pc_n   = skid_pc;
      skid_inst_n = skid_inst;
      opc_n       = out_pc;
      oinst_n     = out_inst;
      ovalid_n    = out_valid;
      ovalid_we   = 1'b0;
      unique case (state)
         FETCH: begin
            if (redirect) begin
               ovalid_n  = 1'b0;
               ovalid_we = 1'b1;
               oinst_n   = '0;
               if (xfer) begin
                  pc_n = redirect_pc;
               end else begin
                  tgt_n   = redirect_pc;
                  state_n = DRAIN;
               end
            end else if (xfer) begin
               pc_n = pc + PC_STEP;
               if (stall) begin
                  skid_pc_n   = pc;
                  skid_inst_n = imem_rdata;
                  state_n     = HOLD;
               end else begin
                  opc_n     = pc;
                  oinst_n   = imem_rdata;
                  ovalid_n  = 1'b1;
                  ovalid_we = 1'b1;
               end
            end else if (!stall) begin
               ovalid_n  = 1'b0;
               ovalid_we = 1'b1;
            end
         end
         HOLD: begin
            if (redirect) begin
               ovalid_n  = 1'b0;
               ovalid_we = 1'b1;
               oinst_n   = '0;
               pc_n      = redirect_pc;
               state_n   = FETCH;
            end else if (!stall) begin
               opc_n     = skid_pc;
               oinst_n   = skid_inst;
               ovalid_n  = 1'b1;
               ovalid_we = 1'b1;
               state_n   = FETCH;
            end
         end
         DRAIN: begin
            if (redirect) begin
               tgt_n     = redirect_pc;
               ovalid_n  = 1'b0;
               ovalid_we = 1'b1;
               oinst_n   = '0;
            end
            if (xfer) begin
               pc_n    = tgt_n;
               state_n = FETCH;
            end
         end
         default: state_n = FETCH;
      endcase
   end

   // State, pc, skid and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         tgt       <= '0;
         skid_pc   <= '0;
         skid_inst <= '0;
         out_pc    <= '0;
         out_inst  <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         tgt       <= tgt_n;
         skid_pc   <= skid_pc_n;
         skid_inst <= skid_inst_n;
         out_pc    <= opc_n;
         out_inst  <= oinst_n;
         if (ovalid_we) out_valid <= ovalid_n;
      end
   end

`ifdef IFETCH_PERFCNT_EN
   // Saturating counters of out_valid loads to 1 and to 0
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_bubbles <= '0;
      end else if (ovalid_we) begin
         if (ovalid_n && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
         if (!ovalid_n && (perf_bubbles != '1)) perf_bubbles <= perf_bubbles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit. It runs directed scenarios and then random
// traffic, checking every cycle against a transaction-level model. The
// memory returns addr+0x100 on every ack.
module tb_ifetch_unit;

   localparam int W = 33;

   logic         clk = 1'b0;
   logic         rst, stall, redirect, imem_ack;
   logic [W-1:0] redirect_pc, imem_rdata;
   logic         imem_req, out_valid;
   logic [W-1:0] imem_addr, out_pc, out_inst;
`ifdef IFETCH_PERFCNT_EN
   logic [31:0]  perf_fetched, perf_bubbles;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   ifetch_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .out_pc(out_pc),
      .out_inst(out_inst),
`ifdef IFETCH_PERFCNT_EN
      .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles),
`endif
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   // Reference model: the address the fetcher is reading, a queue of at
   // most one stalled fetch, and a queue of at most one pending redirect
   // target that waits for an abandoned read to complete.
   typedef struct packed { logic [W-1:0] pc; logic [W-1:0] inst; } pair_t;
   pair_t        skid_q[$];
   logic [W-1:0] drain_q[$];
   logic [W-1:0] m_pc, m_opc, m_oinst;
   logic         m_ovalid;

   function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
      return a + 33'h100;
   endfunction

   task automatic model_reset();
      skid_q.delete();
      drain_q.delete();
      m_pc = '0; m_opc = '0; m_oinst = '0; m_ovalid = 1'b0;
   endtask

   task automatic model_step(input logic r, s, rd, input logic [W-1:0] rp, input logic a);
      pair_t p;
      logic  req;
      if (r) begin
         model_reset();
         return;
      end
      req = (skid_q.size() == 0);
      if (drain_q.size() != 0) begin
         if (rd) begin
            drain_q[0] = rp;
            m_ovalid   = 1'b0;
            m_oinst    = '0;
         end
         if (a) m_pc = drain_q.pop_front();
      end else if (!req) begin
         if (rd) begin
            skid_q.delete();
            m_ovalid = 1'b0;
            m_oinst  = '0;
            m_pc     = rp;
         end else if (!s) begin
            p        = skid_q.pop_front();
            m_opc    = p.pc;
            m_oinst  = p.inst;
            m_ovalid = 1'b1;
         end
      end else if (rd) begin
         m_ovalid = 1'b0;
         m_oinst  = '0;
         if (a) m_pc = rp;
         else   drain_q.push_back(rp);
      end else if (a) begin
         p.pc   = m_pc;
         p.inst = mem_word(m_pc);
         if (s) begin
            skid_q.push_back(p);
         end else begin
            m_opc    = p.pc;
            m_oinst  = p.inst;
            m_ovalid = 1'b1;
         end
         m_pc = m_pc + 33'd1;
      end else if (!s) begin
         m_ovalid = 1'b0;
      end
   endtask

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // One clock: drive at negedge, compare the outputs, then advance the model on the edge.
   task automatic cycle(input logic r, s, rd, input logic [W-1:0] rp, input logic a);
      logic exp_req;
      @(negedge clk);
      rst = r; stall = s; redirect = rd; redirect_pc = rp; imem_ack = a;
      imem_rdata = a ? mem_word(imem_addr) : W'($urandom());
      #1;
      exp_req = !r && (skid_q.size() == 0);
      chk("imem_req", {32'd0, imem_req}, {32'd0, exp_req});
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
      chk("out_valid", {32'd0, out_valid}, {32'd0, m_ovalid});
      chk("out_pc", out_pc, m_opc);
      chk("out_inst", out_inst, m_oinst);
      @(posedge clk);
      model_step(r, s, rd, rp, a);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_ack = 1'b0; imem_rdata = '0;
      @(posedge clk); #1;
      model_reset();
      cycle(1, 0, 0, '0, 1);
      chk("rst_valid", {32'd0, out_valid}, 33'd0);
      chk("rst_pc", out_pc, 33'd0);
      chk("rst_inst", out_inst, 33'd0);
      chk("rst_req", {32'd0, imem_req}, 33'd0);

      // Zero-wait memory: one instruction per cycle
      for (int k = 0; k < 4; k++) begin
         cycle(0, 0, 0, '0, 1);
         chk("zw_pc", out_pc, W'(k));
         chk("zw_inst", out_inst, W'(33'h100 + k));
         chk("zw_valid", {32'd0, out_valid}, 33'd1);
      end

      // Ack every third cycle
      cycle(0, 0, 0, '0, 0); chk("a3_valid0", {32'd0, out_valid}, 33'd0);
      cycle(0, 0, 0, '0, 0); chk("a3_valid1", {32'd0, out_valid}, 33'd0);
      chk("a3_addr", imem_addr, 33'd4);
      cycle(0, 0, 0, '0, 1); chk("a3_valid2", {32'd0, out_valid}, 33'd1);
      chk("a3_pc", out_pc, 33'd4);

      // Stall coinciding with ack for pc=5
      cycle(0, 1, 0, '0, 1);
      for (int k = 0; k < 3; k++) begin
         chk("st_req", {32'd0, imem_req}, 33'd0);
         chk("st_pc", out_pc, 33'd4);
         cycle(0, 1, 0, '0, 1);
      end
      cycle(0, 0, 0, '0, 0);
      chk("st_rel_pc", out_pc, 33'd5);
      chk("st_rel_inst", out_inst, 33'h105);
      chk("st_rel_valid", {32'd0, out_valid}, 33'd1);
      chk("st_rel_addr", imem_addr, 33'd6);

      // Redirect to 0x40 while the read for pc=7 is still pending
      cycle(0, 0, 0, '0, 1);
      cycle(0, 0, 1, 33'h40, 0);
      chk("dr_addr0", imem_addr, 33'd7);
      chk("dr_valid0", {32'd0, out_valid}, 33'd0);
      cycle(0, 0, 0, '0, 0);
      chk("dr_addr1", imem_addr, 33'd7);
      cycle(0, 0, 0, '0, 1);
      chk("dr_valid2", {32'd0, out_valid}, 33'd0);
      chk("dr_addr2", imem_addr, 33'h40);
      cycle(0, 0, 0, '0, 1);
      chk("dr_pc", out_pc, 33'h40);
      chk("dr_inst", out_inst, 33'h140);

      // Redirect together with stall in HOLD
      cycle(0, 1, 0, '0, 1);
      cycle(0, 1, 1, 33'h80, 0);
      chk("hr_valid", {32'd0, out_valid}, 33'd0);
      chk("hr_req", {32'd0, imem_req}, 33'd1);
      chk("hr_addr", imem_addr, 33'h80);
      cycle(0, 0, 0, '0, 1);
      chk("hr_pc", out_pc, 33'h80);

      // PC wrap at all-ones, then reset during a wait
      cycle(0, 0, 1, 33'h1_FFFF_FFFF, 1);
      cycle(0, 0, 0, '0, 1);
      chk("wr_pc", out_pc, 33'h1_FFFF_FFFF);
      chk("wr_inst", out_inst, 33'h0FF);
      chk("wr_addr", imem_addr, 33'd0);
      cycle(0, 0, 0, '0, 0);
      cycle(1, 0, 0, '0, 0);
      chk("mr_req", {32'd0, imem_req}, 33'd0);
      chk("mr_valid", {32'd0, out_valid}, 33'd0);
      chk("mr_pc", out_pc, 33'd0);
      chk("mr_inst", out_inst, 33'd0);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         logic [W-1:0] rp;
         rp = ($urandom_range(0, 3) == 0) ? (33'h1_FFFF_FFFF - W'($urandom_range(0, 3)))
                                          : {1'($urandom_range(0, 1)), 32'($urandom())};
         cycle(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 9) < 3),
               ($urandom_range(0, 9) == 0),
               rp,
               ($urandom_range(0, 1) == 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
